// File: rtl/fan_ctrl_if.sv
// Fan controller bus: tach strobe, regulation config in, PWM duty and status out.
// master drives tach/config and observes status; slave is the controller itself.
interface fan_ctrl_if #(
    parameter int DW = 10
);
    logic          en;
    logic          tach_vld;
    logic [26:0]   tach_cnt;
    logic [26:0]   target;
    logic [7:0]    deadband;
    logic [DW-1:0] step;
    logic [DW-1:0] duty_min;
    logic [DW-1:0] duty_max;
    logic [DW-1:0] duty;
    logic          duty_upd;
    logic          at_target;
    logic          stall;
    logic [1:0]    state;

    modport master (
        output en, tach_vld, tach_cnt, target, deadband, step, duty_min, duty_max,
        input  duty, duty_upd, at_target, stall, state
    );

    modport slave (
        input  en, tach_vld, tach_cnt, target, deadband, step, duty_min, duty_max,
        output duty, duty_upd, at_target, stall, state
    );
endinterface

// File: rtl/fan_ctrl.sv
// Closed-loop fan speed controller: spin-up at full duty, step regulation into a deadband, stall detect.
// Latency 1 cycle from tach_vld to duty; no backpressure, every strobe is consumed in the cycle it arrives.
module fan_ctrl #(
    parameter int DW         = 10,
    parameter int SPINUP_WIN = 2,
    parameter int STALL_WIN  = 3
) (
    input  logic    CLK_I,
    input  logic    RST_I,
    fan_ctrl_if.slave bus
);
    localparam int WW = (SPINUP_WIN < 1) ? 1 : $clog2(SPINUP_WIN + 1);
    localparam int ZW = (STALL_WIN  < 1) ? 1 : $clog2(STALL_WIN + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPINUP   = 2'd1,
        REGULATE = 2'd2,
        STALL    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          duty_upd_q, duty_upd_d;
    logic          at_target_q, at_target_d;
    logic          stall_q, stall_d;
    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [ZW-1:0] zero_cnt_q, zero_cnt_d;

    logic [27:0]   hi_bound;
    logic [26:0]   lo_bound;
    logic [DW-1:0] floor_eff;
    logic [DW:0]   duty_up, duty_dn;
    logic [DW-1:0] up_sat, dn_sat;
    logic [ZW-1:0] zero_nxt;
    logic [WW-1:0] win_nxt;
    logic          stall_hit;

    always_comb begin
        hi_bound  = {1'b0, bus.target} + {20'd0, bus.deadband};
        lo_bound  = (bus.target >= {19'd0, bus.deadband}) ? bus.target - {19'd0, bus.deadband} : '0;
        // An inverted min/max pair collapses onto duty_max.
        floor_eff = (bus.duty_min > bus.duty_max) ? bus.duty_max : bus.duty_min;
        duty_up   = {1'b0, duty_q} + {1'b0, bus.step};
        duty_dn   = {1'b0, duty_q} - {1'b0, bus.step};
        up_sat    = (duty_up > {1'b0, bus.duty_max}) ? bus.duty_max : duty_up[DW-1:0];
        if (duty_dn[DW] || (duty_dn[DW-1:0] < floor_eff)) begin
            dn_sat = floor_eff;
        end else begin
            dn_sat = duty_dn[DW-1:0];
        end
        zero_nxt  = (bus.tach_cnt == '0) ? zero_cnt_q + 1'b1 : '0;
        win_nxt   = win_cnt_q + 1'b1;
        stall_hit = bus.tach_vld && (zero_nxt == ZW'(STALL_WIN));
    end

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        at_target_d = at_target_q;
        stall_d     = stall_q;
        win_cnt_d   = win_cnt_q;
        zero_cnt_d  = zero_cnt_q;

        if (!bus.en) begin
            state_d     = IDLE;
            duty_d      = '0;
            at_target_d = 1'b0;
            stall_d     = 1'b0;
            win_cnt_d   = '0;
            zero_cnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = SPINUP;
                    duty_d      = bus.duty_max;
                    at_target_d = 1'b0;
                    win_cnt_d   = '0;
                    zero_cnt_d  = '0;
                end
                SPINUP: begin
                    if (stall_hit) begin
                        state_d    = STALL;
                        stall_d    = 1'b1;
                        duty_d     = bus.duty_max;
                        zero_cnt_d = '0;
                    end else if (bus.tach_vld) begin
                        zero_cnt_d = zero_nxt;
                        win_cnt_d  = win_nxt;
                        if (win_nxt == WW'(SPINUP_WIN)) begin
                            state_d = REGULATE;
                        end
                    end
                end
                REGULATE: begin
                    if (stall_hit) begin
                        state_d     = STALL;
                        stall_d     = 1'b1;
                        duty_d      = bus.duty_max;
                        at_target_d = 1'b0;
                        zero_cnt_d  = '0;
                    end else if (bus.tach_vld) begin
                        zero_cnt_d  = zero_nxt;
                        at_target_d = 1'b0;
                        if (bus.tach_cnt < lo_bound) begin
                            duty_d = up_sat;
                        end else if ({1'b0, bus.tach_cnt} > hi_bound) begin
                            duty_d = dn_sat;
                        end else begin
                            at_target_d = 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (bus.tach_vld && (bus.tach_cnt != '0)) begin
                        state_d    = SPINUP;
                        duty_d     = bus.duty_max;
                        win_cnt_d  = '0;
                        zero_cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A forced drop to IDLE is not a regulation event, so it never pulses.
        duty_upd_d = bus.en && (duty_d != duty_q);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            duty_upd_q  <= 1'b0;
            at_target_q <= 1'b0;
            stall_q     <= 1'b0;
            win_cnt_q   <= '0;
            zero_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            duty_upd_q  <= duty_upd_d;
            at_target_q <= at_target_d;
            stall_q     <= stall_d;
            win_cnt_q   <= win_cnt_d;
            zero_cnt_q  <= zero_cnt_d;
        end
    end

    assign bus.duty      = duty_q;
    assign bus.duty_upd  = duty_upd_q;
    assign bus.at_target = at_target_q;
    assign bus.stall     = stall_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_fan_ctrl.sv
// Directed bench for fan_ctrl: inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_fan_ctrl;
    localparam int DW = 10;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fan_ctrl_if #(.DW(DW)) fif ();

    fan_ctrl #(.DW(DW), .SPINUP_WIN(2), .STALL_WIN(3)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (fif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one tach strobe for exactly one rising edge; returns on the following falling edge.
    task automatic pulse(input logic [26:0] c);
        fif.tach_vld = 1'b1;
        fif.tach_cnt = c;
        @(negedge clk);
        fif.tach_vld = 1'b0;
        fif.tach_cnt = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (fif.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fif.state); end
        checks++; if (fif.duty !== 10'd0) begin failures++; $display("FAIL reset_duty got=%0d exp=0", fif.duty); end
        checks++; if ({fif.duty_upd, fif.at_target, fif.stall} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {fif.duty_upd, fif.at_target, fif.stall}); end
        fif.en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (fif.state !== 2'd1) begin failures++; $display("FAIL release_spinup got=%0d exp=1", fif.state); end
        checks++; if (fif.duty !== 10'd1000) begin failures++; $display("FAIL release_duty got=%0d exp=1000", fif.duty); end
    endtask

    task automatic test_spinup();
        pulse(27'd80);
        checks++; if (fif.state !== 2'd1) begin failures++; $display("FAIL spinup_win1 got=%0d exp=1", fif.state); end
        pulse(27'd80);
        checks++; if (fif.state !== 2'd2) begin failures++; $display("FAIL spinup_exit got=%0d exp=2", fif.state); end
        checks++; if (fif.duty !== 10'd1000) begin failures++; $display("FAIL spinup_duty got=%0d exp=1000", fif.duty); end
        fif.step = 10'd500;
        pulse(27'd200);
        checks++; if (fif.duty !== 10'd500) begin failures++; $display("FAIL preset_500 got=%0d exp=500", fif.duty); end
        fif.step = 10'd20;
    endtask

    task automatic test_regulate();
        pulse(27'd80);
        checks++; if (fif.duty !== 10'd520) begin failures++; $display("FAIL reg_up got=%0d exp=520", fif.duty); end
        checks++; if (fif.duty_upd !== 1'b1) begin failures++; $display("FAIL reg_up_upd got=%b exp=1", fif.duty_upd); end
        checks++; if (fif.at_target !== 1'b0) begin failures++; $display("FAIL reg_up_at got=%b exp=0", fif.at_target); end
        @(negedge clk);
        checks++; if (fif.duty_upd !== 1'b0) begin failures++; $display("FAIL reg_upd_one_cycle got=%b exp=0", fif.duty_upd); end
        pulse(27'd103);
        checks++; if (fif.duty !== 10'd520) begin failures++; $display("FAIL reg_hold got=%0d exp=520", fif.duty); end
        checks++; if (fif.at_target !== 1'b1) begin failures++; $display("FAIL reg_hold_at got=%b exp=1", fif.at_target); end
        checks++; if (fif.duty_upd !== 1'b0) begin failures++; $display("FAIL reg_hold_upd got=%b exp=0", fif.duty_upd); end
        pulse(27'd106);
        checks++; if ({fif.duty, fif.at_target} !== {10'd500, 1'b0}) begin failures++; $display("FAIL reg_down got=%0d/%b exp=500/0", fif.duty, fif.at_target); end
        pulse(27'd95);
        checks++; if ({fif.duty, fif.at_target} !== {10'd500, 1'b1}) begin failures++; $display("FAIL reg_lo_edge got=%0d/%b exp=500/1", fif.duty, fif.at_target); end
        pulse(27'd105);
        checks++; if ({fif.duty, fif.at_target} !== {10'd500, 1'b1}) begin failures++; $display("FAIL reg_hi_edge got=%0d/%b exp=500/1", fif.duty, fif.at_target); end
        pulse(27'd94);
        checks++; if ({fif.duty, fif.at_target} !== {10'd520, 1'b0}) begin failures++; $display("FAIL reg_below_lo got=%0d/%b exp=520/0", fif.duty, fif.at_target); end
    endtask

    task automatic test_saturation();
        fif.step = 10'd470;
        pulse(27'd80);
        checks++; if (fif.duty !== 10'd990) begin failures++; $display("FAIL sat_preset_990 got=%0d exp=990", fif.duty); end
        fif.step = 10'd20;
        pulse(27'd80);
        checks++; if (fif.duty !== 10'd1000) begin failures++; $display("FAIL sat_ceiling got=%0d exp=1000", fif.duty); end
        pulse(27'd80);
        checks++; if ({fif.duty, fif.duty_upd} !== {10'd1000, 1'b0}) begin failures++; $display("FAIL sat_ceiling_hold got=%0d/%b exp=1000/0", fif.duty, fif.duty_upd); end
        fif.step = 10'd985;
        pulse(27'd200);
        checks++; if (fif.duty !== 10'd15) begin failures++; $display("FAIL sat_preset_15 got=%0d exp=15", fif.duty); end
        fif.step = 10'd20;
        pulse(27'd200);
        checks++; if (fif.duty !== 10'd10) begin failures++; $display("FAIL sat_floor got=%0d exp=10", fif.duty); end
        fif.target = 27'd3;
        pulse(27'd1);
        checks++; if ({fif.duty, fif.at_target} !== {10'd10, 1'b1}) begin failures++; $display("FAIL sat_lo_clamp got=%0d/%b exp=10/1", fif.duty, fif.at_target); end
        pulse(27'd9);
        checks++; if ({fif.duty, fif.at_target, fif.duty_upd} !== {10'd10, 1'b0, 1'b0}) begin failures++; $display("FAIL sat_floor_hold got=%0d/%b/%b exp=10/0/0", fif.duty, fif.at_target, fif.duty_upd); end
        fif.duty_min = 10'd1200 & 10'h3FF;
        fif.duty_min = 10'd1010;
        pulse(27'd9);
        checks++; if (fif.duty !== 10'd1000) begin failures++; $display("FAIL inverted_min_max got=%0d exp=1000", fif.duty); end
        fif.duty_min = 10'd10;
        fif.target   = 27'd100;
    endtask

    task automatic test_stall();
        fif.step = 10'd600;
        pulse(27'd200);
        checks++; if (fif.duty !== 10'd400) begin failures++; $display("FAIL stall_preset got=%0d exp=400", fif.duty); end
        fif.step = 10'd20;
        pulse(27'd0);
        pulse(27'd0);
        checks++; if ({fif.state, fif.duty, fif.stall} !== {2'd2, 10'd440, 1'b0}) begin failures++; $display("FAIL stall_two_zero got=%0d/%0d/%b exp=2/440/0", fif.state, fif.duty, fif.stall); end
        pulse(27'd0);
        checks++; if (fif.state !== 2'd3) begin failures++; $display("FAIL stall_enter got=%0d exp=3", fif.state); end
        checks++; if ({fif.stall, fif.duty, fif.at_target} !== {1'b1, 10'd1000, 1'b0}) begin failures++; $display("FAIL stall_outputs got=%b/%0d/%b exp=1/1000/0", fif.stall, fif.duty, fif.at_target); end
        pulse(27'd0);
        checks++; if (fif.state !== 2'd3) begin failures++; $display("FAIL stall_stay got=%0d exp=3", fif.state); end
        pulse(27'd50);
        checks++; if ({fif.state, fif.stall, fif.duty} !== {2'd1, 1'b1, 10'd1000}) begin failures++; $display("FAIL stall_recover got=%0d/%b/%0d exp=1/1/1000", fif.state, fif.stall, fif.duty); end
        fif.en = 1'b0;
        @(negedge clk);
        checks++; if ({fif.state, fif.stall, fif.duty} !== {2'd0, 1'b0, 10'd0}) begin failures++; $display("FAIL stall_clear got=%0d/%b/%0d exp=0/0/0", fif.state, fif.stall, fif.duty); end
    endtask

    task automatic test_idle();
        pulse(27'd0);
        pulse(27'd0);
        pulse(27'd0);
        checks++; if ({fif.state, fif.duty} !== {2'd0, 10'd0}) begin failures++; $display("FAIL idle_ignore got=%0d/%0d exp=0/0", fif.state, fif.duty); end
        fif.en = 1'b1;
        pulse(27'd80);
        checks++; if (fif.state !== 2'd1) begin failures++; $display("FAIL idle_entry got=%0d exp=1", fif.state); end
        pulse(27'd80);
        checks++; if (fif.state !== 2'd1) begin failures++; $display("FAIL entry_strobe_ignored got=%0d exp=1", fif.state); end
        pulse(27'd80);
        checks++; if (fif.state !== 2'd2) begin failures++; $display("FAIL idle_to_reg got=%0d exp=2", fif.state); end
    endtask

    task automatic test_priority();
        fif.step = 10'd500;
        pulse(27'd200);
        fif.step = 10'd20;
        checks++; if (fif.duty !== 10'd500) begin failures++; $display("FAIL prio_preset got=%0d exp=500", fif.duty); end
        fif.en = 1'b0;
        pulse(27'd80);
        checks++; if ({fif.state, fif.duty, fif.duty_upd} !== {2'd0, 10'd0, 1'b0}) begin failures++; $display("FAIL prio_en_drop got=%0d/%0d/%b exp=0/0/0", fif.state, fif.duty, fif.duty_upd); end
        fif.en = 1'b1;
        @(negedge clk);
        pulse(27'd80);
        pulse(27'd80);
        pulse(27'd100);
        checks++; if ({fif.state, fif.at_target, fif.duty} !== {2'd2, 1'b1, 10'd1000}) begin failures++; $display("FAIL prio_pre_reset got=%0d/%b/%0d exp=2/1/1000", fif.state, fif.at_target, fif.duty); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({fif.state, fif.duty, fif.at_target, fif.stall, fif.duty_upd} !== {2'd0, 10'd0, 3'b000}) begin failures++; $display("FAIL async_reset got=%0d/%0d/%b/%b/%b exp=0/0/0/0/0", fif.state, fif.duty, fif.at_target, fif.stall, fif.duty_upd); end
    endtask

    initial begin
        rst          = 1'b1;
        fif.en       = 1'b0;
        fif.tach_vld = 1'b0;
        fif.tach_cnt = '0;
        fif.target   = 27'd100;
        fif.deadband = 8'd5;
        fif.step     = 10'd20;
        fif.duty_min = 10'd10;
        fif.duty_max = 10'd1000;
        test_reset();
        test_spinup();
        test_regulate();
        test_saturation();
        test_stall();
        test_idle();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
